// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock flag FIFO.
//   clog2      : ceiling log2, used to size addresses and the fill counter
//   params_ok  : legality check for depth and threshold parameters
//   DEFAULT_*  : default parameter values shared by the RTL and its users
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_MEM_DEPTH  = 16;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                result = result + 1;
                v      = v >> 1;
            end
        end
        return result;
    endfunction

    // Depth must be a power of two (natural pointer wrap) and at least 4;
    // thresholds must be ordered so that almost_empty and almost_full never
    // describe the same fill level.
    function automatic bit params_ok(input int depth, input int afull_lvl, input int aempty_lvl);
        bit ok;
        ok = 1'b1;
        if (depth < 4)                        ok = 1'b0;
        if ((depth & (depth - 1)) != 0)       ok = 1'b0;
        if (aempty_lvl < 0)                   ok = 1'b0;
        if (aempty_lvl >= afull_lvl)          ok = 1'b0;
        if (afull_lvl > depth)                ok = 1'b0;
        return ok;
    endfunction

    // Width of the occupancy count: must hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Handshake/status bundle between a producer/consumer and fifo_sync_flags.
//   master : drives clr, wr_en, din, rd_en; observes data and status
//   slave  : the FIFO side
interface fifo_sync_flags_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH
);
    localparam int CNT_WIDTH = count_width(MEM_DEPTH);

    logic                  clr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_WIDTH-1:0]  count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, wr_en, din, rd_en,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, din, rd_en,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage array for the FIFO.
//   clk   : write clock
//   we    : write enable (already qualified by the caller)
//   waddr : write address, wdata : write data
//   raddr : read address, rdata : asynchronous read data
// Contents are deliberately not reset.
module fifo_mem_dp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_reg [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock parametrised FIFO with registered status flags, fill count,
// programmable almost-full/almost-empty, synchronous flush and sticky
// overflow/underflow. FWFT=1 selects first-word-fall-through reads.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of fifo_sync_flags_if (clr, wr_en, din, rd_en in;
//           dout, full, empty, almost_full, almost_empty, count,
//           overflow, underflow out)
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH,
    parameter int FWFT       = 0,
    parameter int AFULL_LVL  = MEM_DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_sync_flags_if.slave bus
);
    localparam int ADDR_WIDTH = clog2(MEM_DEPTH);
    localparam int CNT_WIDTH  = count_width(MEM_DEPTH);

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   PTR_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [CNT_WIDTH-1:0]  AFULL_CNT  = CNT_WIDTH'(AFULL_LVL);
    localparam logic [CNT_WIDTH-1:0]  AEMPTY_CNT = CNT_WIDTH'(AEMPTY_LVL);

    if (!params_ok(MEM_DEPTH, AFULL_LVL, AEMPTY_LVL)) begin : g_param_error
        $error("fifo_sync_flags: illegal MEM_DEPTH/AFULL_LVL/AEMPTY_LVL combination");
    end

    logic [ADDR_WIDTH:0]     wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH:0]     rd_ptr_reg, rd_ptr_next;
    logic [CNT_WIDTH-1:0]    count_reg, count_next;
    logic                    full_reg, full_next;
    logic                    empty_reg, empty_next;
    logic                    afull_reg, afull_next;
    logic                    aempty_reg, aempty_next;
    logic                    ovf_reg, ovf_next;
    logic                    unf_reg, unf_next;
    logic [DATA_WIDTH-1:0]   dout_reg, dout_next;

    logic                    wr_ok;
    logic                    rd_ok;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_raddr;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    // Acceptance uses only the registered (pre-edge) flags, so a read never
    // frees space for a same-cycle write and vice versa.
    assign wr_ok = bus.wr_en & ~full_reg;
    assign rd_ok = bus.rd_en & ~empty_reg;

    // rst_n gating keeps a write from landing while reset is held.
    assign mem_we = wr_ok & ~bus.clr & rst_n;

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_reg[ADDR_WIDTH-1:0]),
        .wdata (bus.din),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Pointer, count and flag next-state. Flags are derived from the
    // next-state pointers/count so they are registered yet always agree
    // with count in the same cycle.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        unf_next    = unf_reg;

        if (bus.clr) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
            ovf_next    = 1'b0;
            unf_next    = 1'b0;
        end else begin
            if (wr_ok) wr_ptr_next = wr_ptr_reg + PTR_ONE;
            if (rd_ok) rd_ptr_next = rd_ptr_reg + PTR_ONE;
            if (wr_ok && !rd_ok)      count_next = count_reg + CNT_ONE;
            else if (rd_ok && !wr_ok) count_next = count_reg - CNT_ONE;
            ovf_next = ovf_reg | (bus.wr_en & full_reg);
            unf_next = unf_reg | (bus.rd_en & empty_reg);
        end

        empty_next  = (wr_ptr_next == rd_ptr_next);
        full_next   = (wr_ptr_next[ADDR_WIDTH] != rd_ptr_next[ADDR_WIDTH]) &&
                      (wr_ptr_next[ADDR_WIDTH-1:0] == rd_ptr_next[ADDR_WIDTH-1:0]);
        afull_next  = (count_next >= AFULL_CNT);
        aempty_next = (count_next <= AEMPTY_CNT);
    end

    if (FWFT != 0) begin : g_fwft
        // The output register is preloaded with whatever will be the head
        // after this edge. If that head is the word being written right now
        // (FIFO empty, or one entry left and being popped) the memory does
        // not hold it yet, so it is bypassed from din.
        assign mem_raddr = rd_ptr_next[ADDR_WIDTH-1:0];

        always_comb begin
            dout_next = dout_reg;
            if (!empty_next) begin
                if (wr_ok && (rd_ptr_next == wr_ptr_reg)) begin
                    dout_next = bus.din;
                end else begin
                    dout_next = mem_rdata;
                end
            end
        end
    end else begin : g_std
        // Registered read: the head is captured on an accepted read.
        assign mem_raddr = rd_ptr_reg[ADDR_WIDTH-1:0];

        always_comb begin
            dout_next = dout_reg;
            if (!bus.clr && rd_ok) begin
                dout_next = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            afull_reg  <= 1'b0;
            aempty_reg <= 1'b1;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
            dout_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= full_next;
            empty_reg  <= empty_next;
            afull_reg  <= afull_next;
            aempty_reg <= aempty_next;
            ovf_reg    <= ovf_next;
            unf_reg    <= unf_next;
            dout_reg   <= dout_next;
        end
    end

    assign bus.dout         = dout_reg;
    assign bus.full         = full_reg;
    assign bus.empty        = empty_reg;
    assign bus.almost_full  = afull_reg;
    assign bus.almost_empty = aempty_reg;
    assign bus.count        = count_reg;
    assign bus.overflow     = ovf_reg;
    assign bus.underflow    = unf_reg;

endmodule
